divisor: RTL and testbench
==========================

# divisor

Sequential 32-by-16 unsigned restoring divider. It is the inverse of the 16x16 shift-add multiplier in the arithmetic unit: it takes the 32-bit value a multiply produces and returns a 16-bit quotient and a 16-bit remainder. It uses the same St/Idle/Done start-and-completion handshake as the multiplier. The MIPS datapath uses it for DIV/DIVU into HI/LO.

## Interface
Parameters: none. Widths are fixed at 32/16.

- Clk  input  1  clock; all state changes on the rising edge
- Rst  input  1  synchronous, active-high reset
- St  input  1  start request; sampled only in IDLE
- Dividendo  input  32  dividend; latched on the accepted St
- Divisor  input  16  divisor; latched on the accepted St
- Idle  output  1  high only in IDLE
- Done  output  1  one-cycle pulse; results valid from this cycle on
- Quociente  output  16  quotient, registered
- Resto  output  16  remainder, registered
- Overflow  output  1  quotient does not fit in 16 bits, or Divisor = 0; registered

## Operation
- Datapath registers:
  - 33-bit partial-remainder/quotient register ACC
  - 16-bit divisor register D
  - 5-bit iteration counter
- The four states are IDLE, CHECK, DIV and DONE.
- IDLE:
  - Idle = 1.
  - If St = 1, load ACC = {1'b0, Dividendo}, D = Divisor and counter = 0, then go to CHECK.
  - If St = 0, stay in IDLE.
- CHECK:
  - If ACC[31:16] >= D, which includes D = 0, set Overflow = 1, Quociente = 16'hFFFF and Resto = 16'h0000, then go to DONE.
  - Otherwise set Overflow = 0 and go to DIV.
- DIV (one iteration per cycle):
  - Form T = ACC << 1.
  - If T[32:16] >= {1'b0, D}, set ACC = {T[32:16] - D, T[15:1], 1'b1}.
  - Otherwise set ACC = T.
  - Increment the counter. After the 16th iteration (counter = 15), go to DONE.
- Result capture on the DIV->DONE edge:
  - Quociente = final ACC[15:0]
  - Resto = final ACC[31:16]
- DONE: Done = 1 for exactly one cycle, then go to IDLE.
- Quociente, Resto and Overflow hold their values until the next accepted operation overwrites them.
- Dividendo and Divisor are ignored outside the St-accept edge. Changing them mid-operation has no effect.
- St is ignored in CHECK, DIV and DONE. A St held high through DONE is accepted again in the following IDLE cycle.
- Rst = 1 at any time, including mid-division, aborts the operation and produces the reset state:
  - state = IDLE, Idle = 1, Done = 0
  - Quociente = 0, Resto = 0, Overflow = 0
  - ACC, D and counter cleared

## Timing
- Edge 0 accepts St. The block is in CHECK after edge 0.
- Normal division:
  - 16 DIV iterations occur on edges 2 through 17.
  - Done = 1 in the cycle after edge 17, i.e. 18 cycles after accept.
  - Idle returns to 1 after edge 18.
- Overflow or divide-by-zero: CHECK->DONE on edge 1, so Done = 1 after edge 1 (2 cycles) and Idle = 1 after edge 2.
- Idle drops to 0 on the edge that accepts St.
- Back-to-back throughput is one operation per 19 cycles. This is 18 cycles of latency plus one IDLE cycle, because St is sampled only in IDLE.
- There are no combinational paths from inputs to outputs.

## Configuration
- DIVISOR_SIGNED_EN is a preprocessor macro.
- When DIVISOR_SIGNED_EN is defined, operands are two's complement.
  - At accept, ACC and D are loaded with |Dividendo| and |Divisor|, and the sign of each is recorded.
  - CHECK flags Overflow when either of these holds:
    - |Dividendo|[31:16] >= |Divisor|
    - the magnitude quotient exceeds 16'h7FFF for a positive result, or 16'h8000 for a negative result
  - The magnitude check uses a 17th-bit compare in the final capture. Overflow detected at capture sets Quociente = 16'hFFFF, Resto = 0 and Overflow = 1, with no extra cycle.
  - Quociente is negated when the operand signs differ. Resto takes the sign of Dividendo.
  - Latency is identical to the unsigned build.
- When DIVISOR_SIGNED_EN is not defined, the block is pure unsigned as described above and contains no sign logic.

## Test plan
- Dividendo = 32'd100, Divisor = 16'd7, pulse St -> Done exactly 18 cycles after accept; Quociente = 16'd14, Resto = 16'd2, Overflow = 0.
- Dividendo = 32'hFFFE_0001, Divisor = 16'hFFFF -> Quociente = 16'hFFFF, Resto = 16'h0000, Overflow = 0.
- Divisor = 0 with any Dividendo, and separately Dividendo = 32'h0007_0000 with Divisor = 16'd7 -> Overflow = 1, Quociente = 16'hFFFF, Resto = 0, Done 2 cycles after accept.
- Start 1000/3, assert Rst for one cycle at iteration 8 -> next cycle Idle = 1, Done = 0, Quociente = Resto = 0; then 1000/3 completes with 333 r 1.
- Start 100/7, then toggle St and change Dividendo/Divisor during DIV -> result is still 14 r 2 and exactly one Done pulse.
- With DIVISOR_SIGNED_EN defined: -100/7 -> Quociente = 16'hFFF2, Resto = 16'hFFFE. Also 32'h0000_8000 / 16'd1 -> Overflow = 1.

Source files
------------

// File: rtl/divisor_if.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_if
//  Description : Start/completion handshake and operand/result bus of the
//                32-by-16 divider. The master drives the operands and St, the
//                slave (the divider) returns Idle/Done and the registered
//                results.
//  Revision    : 1.0  initial release
// ============================================================================
interface divisor_if;
  logic        St;
  logic [31:0] Dividendo;
  logic [15:0] Divisor;
  logic        Idle;
  logic        Done;
  logic [15:0] Quociente;
  logic [15:0] Resto;
  logic        Overflow;

  // Requester side: issues operations and observes completion.
  modport master (
    output St, Dividendo, Divisor,
    input  Idle, Done, Quociente, Resto, Overflow
  );

  // Divider side.
  modport slave (
    input  St, Dividendo, Divisor,
    output Idle, Done, Quociente, Resto, Overflow
  );
endinterface
`default_nettype wire

// File: rtl/divisor.sv
`default_nettype none
// ============================================================================
//  Module      : divisor
//  Description : Sequential 32-by-16 restoring divider with a St/Idle/Done
//                handshake. One quotient bit per cycle; 18 cycles from accept
//                to Done for a normal division, 2 cycles when the quotient
//                cannot fit in 16 bits or the divisor is zero.
//                Optional build macro DIVISOR_SIGNED_EN selects two's
//                complement operands (magnitude division plus sign fix-up at
//                capture); without it the block is purely unsigned.
//  Revision    : 1.0  initial release
// ============================================================================
module divisor (
  input  wire logic  Clk,
  input  wire logic  Rst,
  divisor_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DIV   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] C_LAST_ITER = 5'd15;

  state_t      state_q, state_d;
  logic [32:0] acc_q,   acc_d;     // partial remainder (upper) / quotient (lower)
  logic [15:0] d_q,     d_d;       // latched divisor (magnitude in signed build)
  logic [4:0]  cnt_q,   cnt_d;     // iteration counter 0..15
  logic [15:0] quo_q,   quo_d;
  logic [15:0] rem_q,   rem_d;
  logic        ovf_q,   ovf_d;

  // Operand values loaded into ACC/D on the accept edge.
  logic [31:0] w_a_load;
  logic [15:0] w_b_load;

  // One restoring iteration computed from the current ACC.
  logic [32:0] w_t;
  logic [16:0] w_t_hi;
  logic [16:0] w_t_sub;
  logic [32:0] w_acc_step;

  // Results as they would be captured at the end of the last iteration.
  logic [15:0] w_cap_quo;
  logic [15:0] w_cap_rem;
  logic        w_cap_ovf;

`ifdef DIVISOR_SIGNED_EN
  logic        negq_q, negq_d;     // quotient must be negated
  logic        negr_q, negr_d;     // remainder takes the dividend's sign
  logic [15:0] w_q_mag;
  logic [15:0] w_r_mag;
  logic [16:0] w_q_limit;

  // Magnitudes of the incoming operands; 32'h8000_0000 and 16'h8000 map to
  // themselves, which is the correct unsigned magnitude.
  always_comb begin
    w_a_load = bus.Dividendo[31] ? (32'd0 - bus.Dividendo) : bus.Dividendo;
    w_b_load = bus.Divisor[15]   ? (16'd0 - bus.Divisor)   : bus.Divisor;
  end

  // Sign fix-up of the magnitude result and the 16-bit signed range check.
  always_comb begin
    w_q_mag   = w_acc_step[15:0];
    w_r_mag   = w_acc_step[31:16];
    w_q_limit = negq_q ? 17'h0_8000 : 17'h0_7FFF;
    w_cap_ovf = ({1'b0, w_q_mag} > w_q_limit);
    if (w_cap_ovf) begin
      w_cap_quo = 16'hFFFF;
      w_cap_rem = 16'h0000;
    end else begin
      w_cap_quo = negq_q ? (16'd0 - w_q_mag) : w_q_mag;
      w_cap_rem = negr_q ? (16'd0 - w_r_mag) : w_r_mag;
    end
  end
`else
  // Unsigned build: operands are used as-is and the final ACC is the result.
  always_comb begin
    w_a_load  = bus.Dividendo;
    w_b_load  = bus.Divisor;
    w_cap_quo = w_acc_step[15:0];
    w_cap_rem = w_acc_step[31:16];
    w_cap_ovf = 1'b0;
  end
`endif

  // Shift ACC left, trial-subtract D from the top 17 bits, keep on success.
  always_comb begin
    w_t     = acc_q << 1;
    w_t_hi  = w_t[32:16];
    w_t_sub = w_t_hi - {1'b0, d_q};
    if (w_t_hi >= {1'b0, d_q}) begin
      w_acc_step = {w_t_sub, w_t[15:1], 1'b1};
    end else begin
      w_acc_step = w_t;
    end
  end

  // Next-state and datapath update for the IDLE/CHECK/DIV/DONE sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
`ifdef DIVISOR_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.St) begin
          acc_d   = {1'b0, w_a_load};
          d_d     = w_b_load;
          cnt_d   = 5'd0;
`ifdef DIVISOR_SIGNED_EN
          negq_d  = bus.Dividendo[31] ^ bus.Divisor[15];
          negr_d  = bus.Dividendo[31];
`endif
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        // A high half >= D means a quotient of 2^16 or more; D = 0 lands
        // here too because any value is >= 0.
        if (acc_q[31:16] >= d_q) begin
          ovf_d   = 1'b1;
          quo_d   = 16'hFFFF;
          rem_d   = 16'h0000;
          state_d = S_DONE;
        end else begin
          ovf_d   = 1'b0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        acc_d = w_acc_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == C_LAST_ITER) begin
          quo_d   = w_cap_quo;
          rem_d   = w_cap_rem;
          ovf_d   = w_cap_ovf;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      acc_q   <= 33'd0;
      d_q     <= 16'd0;
      cnt_q   <= 5'd0;
      quo_q   <= 16'd0;
      rem_q   <= 16'd0;
      ovf_q   <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
`ifdef DIVISOR_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  // Handshake flags decode directly from the state register.
  assign bus.Idle      = (state_q == S_IDLE);
  assign bus.Done      = (state_q == S_DONE);
  assign bus.Quociente = quo_q;
  assign bus.Resto     = rem_q;
  assign bus.Overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_divisor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divisor
//  Description : Self-checking bench for divisor. A behavioural model derives
//                quotient, remainder, overflow and Done latency from plain
//                integer division; a single compare process checks the DUT
//                on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divisor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  divisor_if bus ();

  divisor u_dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected-result tracking shared by driver and compare process.
  bit          armed   = 1'b0;
  bit          pending = 1'b0;
  int          acc_cyc;
  int          exp_edges;
  logic [15:0] exp_q, exp_r;
  logic        exp_ov;
  logic [15:0] last_q = 16'd0;
  logic [15:0] last_r = 16'd0;
  logic        last_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Division as plain arithmetic; edges = clock edges from accept to the
  // cycle in which Done is high.
  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic ov, output int edges);
`ifdef DIVISOR_SIGNED_EN
    longint sa, sb, ma, mb, qm, rm;
    bit     neg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    if ((ma >> 16) >= mb) begin
      ov = 1'b1; q = 16'hFFFF; r = 16'h0000; edges = 1;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
      edges = 17;
      if (neg ? (qm > 32768) : (qm > 32767)) begin
        ov = 1'b1; q = 16'hFFFF; r = 16'h0000;
      end else begin
        ov = 1'b0;
        q  = neg ? 16'(-qm) : 16'(qm);
        r  = (sa < 0) ? 16'(-rm) : 16'(rm);
      end
    end
`else
    longint ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    if (ub == 0 || (ua / ub) > 65535) begin
      ov = 1'b1; q = 16'hFFFF; r = 16'h0000; edges = 1;
    end else begin
      ov = 1'b0; q = 16'(ua / ub); r = 16'(ua % ub); edges = 17;
    end
`endif
  endtask

  // Compare process: Done cycle, busy cycles and idle/hold cycles.
  always @(negedge clk) begin
    if (armed) begin
      if (bus.Done === 1'b1) begin
        if (!pending) begin
          chk("done_while_idle", 32'(bus.Done), 32'd0);
        end else begin
          chk("done_latency", 32'(cyc - acc_cyc), 32'(exp_edges));
          chk("quociente",    32'(bus.Quociente), 32'(exp_q));
          chk("resto",        32'(bus.Resto),     32'(exp_r));
          chk("overflow",     32'(bus.Overflow),  32'(exp_ov));
          chk("idle_at_done", 32'(bus.Idle),      32'd0);
          last_q  = exp_q;
          last_r  = exp_r;
          last_ov = exp_ov;
          pending = 1'b0;
        end
      end else if (!pending) begin
        chk("idle_flag",      32'(bus.Idle),      32'd1);
        chk("hold_quociente", 32'(bus.Quociente), 32'(last_q));
        chk("hold_resto",     32'(bus.Resto),     32'(last_r));
        chk("hold_overflow",  32'(bus.Overflow),  32'(last_ov));
      end else begin
        chk("idle_busy", 32'(bus.Idle), 32'd0);
        if (cyc - acc_cyc > exp_edges) begin
          chk("done_timeout", 32'(cyc - acc_cyc), 32'(exp_edges));
          pending = 1'b0;
        end
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [15:0] b);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (pending && g < 100);
    @(negedge clk);
    bus.Dividendo = a;
    bus.Divisor   = b;
    bus.St        = 1'b1;
    @(posedge clk);
    #1;
    bus.St = 1'b0;
    model(a, b, exp_q, exp_r, exp_ov, exp_edges);
    acc_cyc = cyc;
    pending = 1'b1;
  endtask

  task automatic wait_done();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (pending && g < 100);
    @(negedge clk);
  endtask

  // Pin the model with hand-computed values, then run the operation.
  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        input logic [15:0] hq, input logic [15:0] hr, input logic hov);
    logic [15:0] mq, mr;
    logic        mov;
    int          me;
    model(a, b, mq, mr, mov, me);
    chk("model_q",  32'(mq),  32'(hq));
    chk("model_r",  32'(mr),  32'(hr));
    chk("model_ov", 32'(mov), 32'(hov));
    start_op(a, b);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.St        = 1'b0;
    bus.Dividendo = 32'd0;
    bus.Divisor   = 16'd0;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;             // reset state is checked while rst is still high
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifndef DIVISOR_SIGNED_EN
    run_op(32'd100,        16'd7,     16'd14,    16'd2,  1'b0);
    run_op(32'hFFFE_0001,  16'hFFFF,  16'hFFFF,  16'd0,  1'b0);
    run_op(32'd12345,      16'd0,     16'hFFFF,  16'd0,  1'b1);
    run_op(32'h0007_0000,  16'd7,     16'hFFFF,  16'd0,  1'b1);
    run_op(32'h0006_FFFF,  16'd7,     16'hFFFF,  16'd6,  1'b0);
    run_op(32'd5,          16'd9,     16'd0,     16'd5,  1'b0);

    // Reset during iteration 8 of 1000/3.
    start_op(32'd1000, 16'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pending = 1'b0;
    last_q  = 16'd0;
    last_r  = 16'd0;
    last_ov = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd1000,       16'd3,     16'd333,   16'd1,  1'b0);

    // Operands and St disturbed mid-division must not affect the result.
    start_op(32'd100, 16'd7);
    repeat (4) @(negedge clk);
    bus.St        = 1'b1;
    bus.Dividendo = 32'hFFFF_FFFF;
    bus.Divisor   = 16'd1;
    repeat (3) @(negedge clk);
    bus.St        = 1'b0;
    bus.Dividendo = 32'd0;
    bus.Divisor   = 16'd0;
    wait_done();
    repeat (5) @(negedge clk);
`else
    run_op(32'hFFFF_FF9C,  16'd7,     16'hFFF2,  16'hFFFE, 1'b0);
    run_op(32'h0000_8000,  16'd1,     16'hFFFF,  16'h0000, 1'b1);
    run_op(32'hFFFF_8000,  16'd1,     16'h8000,  16'h0000, 1'b0);
    run_op(32'd100,        16'hFFF9,  16'hFFF2,  16'd2,    1'b0);
    run_op(32'd100,        16'd0,     16'hFFFF,  16'h0000, 1'b1);
    run_op(32'd100,        16'd7,     16'd14,    16'd2,    1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
